// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// forward-select codes, Tuse/Tnew constants and the per-stage usage record.
package hazard_ctrl_pkg;

  localparam int RW = 5;
  localparam int TW = 2;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_E    = 2'd1,
    FWD_M    = 2'd2,
    FWD_W    = 2'd3
  } fwd_t;

  localparam logic [TW-1:0] T0 = 2'd0;
  localparam logic [TW-1:0] T1 = 2'd1;
  localparam logic [TW-1:0] T2 = 2'd2;

  typedef struct packed {
    logic [RW-1:0] a1;
    logic [RW-1:0] a2;
    logic [RW-1:0] a3;
    logic          we;
    logic [TW-1:0] tnew;
  } stage_rec_t;

  // Writes to $0 are architecturally discarded, so they never produce a hazard.
  function automatic logic rec_hit(stage_rec_t rec, logic [RW-1:0] r);
    return (r != '0) && rec.we && (rec.a3 == r);
  endfunction

  function automatic logic [TW-1:0] tnew_dec(logic [TW-1:0] t);
    return (t == T0) ? T0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage decoder fields into the hazard controller, stall and forward selects out.
interface hazard_ctrl_if
  import hazard_ctrl_pkg::*;
;
  logic [RW-1:0] a1_d;
  logic [RW-1:0] a2_d;
  logic [RW-1:0] a3_d;
  logic          grf_en_d;
  logic [TW-1:0] tuse_rs_d;
  logic [TW-1:0] tuse_rt_d;
  logic [TW-1:0] tnew_d;
  logic          stall;
  logic [1:0]    fwd_d_rs;
  logic [1:0]    fwd_d_rt;
  logic [1:0]    fwd_e_rs;
  logic [1:0]    fwd_e_rt;
  logic [1:0]    fwd_m_rt;

  modport master (
    output a1_d, a2_d, a3_d, grf_en_d, tuse_rs_d, tuse_rt_d, tnew_d,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );

  modport slave (
    input  a1_d, a2_d, a3_d, grf_en_d, tuse_rs_d, tuse_rt_d, tnew_d,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt
  );

endinterface

// File: rtl/hazard_ctrl_stage_reg.sv
// One shadow-pipeline record register: clears on reset or bubble, optionally
// counts the producer's remaining latency down by one as it advances.
module hazard_stage_reg
  import hazard_ctrl_pkg::*;
#(
  parameter bit DEC_TNEW = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bubble,
  input  stage_rec_t d,
  output stage_rec_t q
);

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q <= '0;
    end else begin
      q <= d;
      if (DEC_TNEW) q.tnew <= tnew_dec(d.tnew);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline; tracks E/M/W register
// usage and resolves each operand against the nearest in-flight producer.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  stage_rec_t d_rec, e_rec, m_rec, w_rec;
  logic       stall_rs, stall_rt, stall;

  always_comb begin
    d_rec      = '0;
    d_rec.a1   = bus.a1_d;
    d_rec.a2   = bus.a2_d;
    d_rec.a3   = bus.a3_d;
    d_rec.we   = bus.grf_en_d;
    d_rec.tnew = bus.tnew_d;
  end

  hazard_stage_reg #(.DEC_TNEW(1'b0)) u_e (
    .clk(clk), .reset(reset), .bubble(stall), .d(d_rec), .q(e_rec)
  );
  hazard_stage_reg #(.DEC_TNEW(1'b1)) u_m (
    .clk(clk), .reset(reset), .bubble(1'b0), .d(e_rec), .q(m_rec)
  );
  hazard_stage_reg #(.DEC_TNEW(1'b1)) u_w (
    .clk(clk), .reset(reset), .bubble(1'b0), .d(m_rec), .q(w_rec)
  );

  // The nearest matching stage decides alone; older writes to the same
  // register are shadowed and never forward or stall.
  function automatic fwd_t d_fwd(logic [RW-1:0] r, stage_rec_t e, stage_rec_t m,
                                 stage_rec_t w);
    if (rec_hit(e, r)) return (e.tnew == T0) ? FWD_E : FWD_NONE;
    if (rec_hit(m, r)) return (m.tnew == T0) ? FWD_M : FWD_NONE;
    if (rec_hit(w, r)) return FWD_W;
    return FWD_NONE;
  endfunction

  function automatic fwd_t e_fwd(logic [RW-1:0] r, stage_rec_t m, stage_rec_t w);
    if (rec_hit(m, r)) return (m.tnew == T0) ? FWD_M : FWD_NONE;
    if (rec_hit(w, r)) return FWD_W;
    return FWD_NONE;
  endfunction

  function automatic logic need_stall(logic [RW-1:0] r, logic [TW-1:0] tuse,
                                      stage_rec_t e, stage_rec_t m);
    if (rec_hit(e, r)) return e.tnew > tuse;
    if (rec_hit(m, r)) return m.tnew > tuse;
    return 1'b0;
  endfunction

  always_comb begin
    stall_rs     = need_stall(bus.a1_d, bus.tuse_rs_d, e_rec, m_rec);
    stall_rt     = need_stall(bus.a2_d, bus.tuse_rt_d, e_rec, m_rec);
    stall        = stall_rs | stall_rt;
    bus.stall    = stall;
    bus.fwd_d_rs = d_fwd(bus.a1_d, e_rec, m_rec, w_rec);
    bus.fwd_d_rt = d_fwd(bus.a2_d, e_rec, m_rec, w_rec);
    bus.fwd_e_rs = e_fwd(e_rec.a1, m_rec, w_rec);
    bus.fwd_e_rt = e_fwd(e_rec.a2, m_rec, w_rec);
    bus.fwd_m_rt = rec_hit(w_rec, m_rec.a2) ? FWD_W : FWD_NONE;
  end

endmodule
